// File: rtl/complement_unit.sv
// complement_unit: multi-cycle pass / ones' / two's complement / absolute-value
// engine. Processes CHUNK bits per clock, LSB chunk first, rippling the
// two's-complement increment between chunks. Results are published on F/ovf
// only on the edge that raises done.
module complement_unit #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Captured operand and effective operation (frozen for the whole op).
    logic [WIDTH-1:0] r_a;
    logic             r_inv;    // inverted path selected
    logic             r_twos;   // two's-complement op (inverted + increment)
    logic             r_carry;  // carry into the current chunk
    logic [IDX_W-1:0] r_idx;    // current chunk index
    logic [WIDTH-1:0] r_acc;    // partial result, never exposed directly
    logic [WIDTH-1:0] r_f;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_cap_twos;
    logic             w_cap_inv;
    logic [CHUNK-1:0] w_chunk;
    logic [CHUNK:0]   w_sum;
    logic [CHUNK-1:0] w_res;
    logic [WIDTH-1:0] w_acc_next;

    // Acceptance happens in IDLE and in DONE; start is ignored while running.
    assign w_accept = start && (r_state != S_RUN);
    assign w_last   = (r_idx == LAST_IDX);

    // Effective op decoded from mode and operand sign at capture time.
    assign w_cap_twos = (mode == 2'b10) || ((mode == 2'b11) && A[WIDTH-1]);
    assign w_cap_inv  = (mode == 2'b01) || w_cap_twos;

    // Select the chunk addressed by the current index.
    always_comb begin
        w_chunk = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_chunk = r_a[k*CHUNK +: CHUNK];
            end
        end
    end

    // Chunk adder: inverted chunk plus incoming carry; carry-out feeds the next chunk.
    always_comb begin
        w_sum = {1'b0, ~w_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_res = r_inv ? w_sum[CHUNK-1:0] : w_chunk;
    end

    // Merge the current chunk result into the accumulator image.
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_acc_next[k*CHUNK +: CHUNK] = w_res;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: DONE accepts a new start exactly like IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_next = S_RUN;
            end
            S_RUN: begin
                if (w_last) w_state_next = S_DONE;
            end
            S_DONE: begin
                w_state_next = start ? S_RUN : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture and per-chunk processing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_inv   <= 1'b0;
            r_twos  <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (w_accept) begin
            r_a     <= A;
            r_inv   <= w_cap_inv;
            r_twos  <= w_cap_twos;
            r_carry <= w_cap_twos;
            r_idx   <= '0;
            r_acc   <= '0;
        end else if (r_state == S_RUN) begin
            r_carry <= w_sum[CHUNK];
            r_idx   <= r_idx + 1'b1;
            r_acc   <= w_acc_next;
        end
    end

    // Result publication: F and ovf move only on the edge that leads to done.
    // Overflow is the one case where negation maps the operand onto itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_f   <= '0;
            r_ovf <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            r_f   <= w_acc_next;
            r_ovf <= r_twos && (r_a == MIN_NEG);
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign F    = r_f;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_complement_unit.sv
// Scoreboard bench for complement_unit (WIDTH=16, CHUNK=4).
module tb_complement_unit;

    localparam int W = 16;
    localparam int C = 4;
    localparam int N = W / C;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   mode;
    logic [W-1:0] A;
    logic         busy;
    logic         done;
    logic [W-1:0] F;
    logic         ovf;

    complement_unit #(.WIDTH(W), .CHUNK(C)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .mode (mode),
        .A    (A),
        .busy (busy),
        .done (done),
        .F    (F),
        .ovf  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] f;
        logic         o;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_chk  = 0;
    int           n_pass = 0;
    int           cyc    = 0;
    int           last_done_cyc = -1;
    int           prev_done_cyc = -1;
    logic [W-1:0] prev_f = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: negation modulo 2^W; overflow when negation maps a nonzero value onto itself.
    function automatic exp_t model(input logic [W-1:0] a, input logic [1:0] m);
        exp_t e;
        logic [W-1:0] neg;
        bit twos;
        neg  = W'((1 << W) - int'(a));
        twos = (m == 2'd2) || (m == 2'd3 && a >= (1 << (W-1)));
        case (m)
            2'd0:    e.f = a;
            2'd1:    e.f = ~a;
            default: e.f = twos ? neg : a;
        endcase
        e.o   = twos && (neg == a) && (a != 0);
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: pops one expectation per done pulse; also checks F holds while busy.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_f = '0;
        end else begin
            if (busy) check("F_hold_busy", 32'(F), 32'(prev_f));
            if (done) begin
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                if (sb.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_done: done=1 with no pending op, F=0x%0h", F);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("F", 32'(F), 32'(e.f));
                    check("ovf", 32'(ovf), 32'(e.o));
                    check("latency", 32'(cyc - e.cyc), 32'(N));
                end
            end
            prev_f = F;
        end
    end

    task automatic push_exp(input logic [W-1:0] a, input logic [1:0] m);
        exp_t e;
        e     = model(a, m);
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 4*N + 10; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL timeout: %0d ops still pending, busy=%0b", sb.size(), busy);
            sb.delete();
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [1:0] m);
        @(negedge clk);
        start = 1'b1; A = a; mode = m;
        @(posedge clk); #1;
        push_exp(a, m);
        start = 1'b0;
        wait_drain();
    endtask

    logic [W-1:0] dir_a[9] = '{16'h00F0, 16'h0001, 16'h0000, 16'h8000, 16'hFFFB,
                               16'h0007, 16'h8000, 16'h1234, 16'h7FFF};
    logic [1:0]   dir_m[9] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd2};

    initial begin
        start = 1'b0; mode = 2'd0; A = '0;
        rst_n = 1'b0;
        #1;
        check("rst_F", 32'(F), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        for (int i = 0; i < 9; i++) do_op(dir_a[i], dir_m[i]);

        // start pulse during busy must be ignored
        @(negedge clk);
        start = 1'b1; A = 16'h0F0F; mode = 2'd1;
        @(posedge clk); #1;
        push_exp(16'h0F0F, 2'd1);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; A = 16'h1234; mode = 2'd2;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (3) @(posedge clk);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        start = 1'b1; A = 16'h00FF; mode = 2'd2;
        @(posedge clk); #1;
        push_exp(16'h00FF, 2'd2);
        A = 16'hA5A5; mode = 2'd3;
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 4*N + 10; i++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) begin
                n_chk++;
                $display("FAIL b2b_first_done: no done within bound");
            end
        end
        @(posedge clk); #1;
        push_exp(16'hA5A5, 2'd3);
        start = 1'b0;
        wait_drain();
        check("b2b_gap", 32'(last_done_cyc - prev_done_cyc), 32'(N + 1));

        // Reset in the middle of an operation
        do_op(16'h00F0, 2'd1);
        @(negedge clk);
        start = 1'b1; A = 16'h0123; mode = 2'd2;
        @(posedge clk); #1;
        push_exp(16'h0123, 2'd2);
        start = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_F", 32'(F), 32'h0);
        check("midrst_ovf", 32'(ovf), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_done", 32'(done), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2*N) @(posedge clk);
        do_op(16'h8000, 2'd3);

        // Randomised operations with edge-value bias
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra;
            logic [1:0]   rm;
            ra = W'($urandom);
            rm = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 7))
                0: ra = 16'h8000;
                1: ra = 16'h0000;
                2: ra = 16'hFFFF;
                default: ;
            endcase
            do_op(ra, rm);
        end

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
